mul4_seq: RTL and testbench
===========================

MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 Port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Port: A  input  4  unsigned multiplicand; sampled on the accepting edge.
REQ-006 Port: B  input  4  unsigned multiplier; sampled on the accepting edge.
REQ-007 Port: P  output  8  unsigned product register; holds last completed result.
REQ-008 Port: busy  output  1  high while an operation is in progress (LOAD/RUN).
REQ-009 Port: done  output  1  one-cycle pulse marking P updated with a new result.
REQ-010 Parameter: none; widths fixed at 4x4 -> 8.

Function
REQ-011 Datapath SHALL consist of registers M[3:0], ACC[3:0], Q[3:0], CNT[2:0], plus one 4-bit adder instance (sum4), with ports S, C_out, A, B, c_in and c_in tied to 0.
REQ-012 The block SHALL contain exactly one adder; all additions SHALL go through it.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE and start=1 at edge N: M<=A, Q<=B, ACC<=0, CNT<=0, state<=RUN.
REQ-015 IDLE and start=0: all registers hold, state stays IDLE.
REQ-016 RUN, each edge: if Q[0]=1 then {C,ACC'}=ACC+M via adder, else {C,ACC'}={0,ACC}; then {ACC,Q}<={C,ACC',Q[3:1]}; CNT<=CNT+1.
REQ-017 RUN, when the edge performs the 4th iteration (CNT=3 before the edge): P<={ACC_new,Q_new}, state<=DONE.
REQ-018 Timing: start accepted at edge N; iterations on edges N+1..N+4; P valid and done=1 from edge N+4 to edge N+5; state<=IDLE at edge N+5.
REQ-019 busy SHALL be 1 exactly from edge N to edge N+4 (4 cycles), 0 otherwise.
REQ-020 done SHALL be 1 only while state=DONE (exactly one cycle per operation).
REQ-021 start SHALL be ignored while in RUN or DONE; no queuing of requests.
REQ-022 A and B changes after the accepting edge SHALL NOT affect the running operation.
REQ-023 P SHALL hold its value from completion until the next completion; it SHALL NOT change on start acceptance.
REQ-024 Result SHALL equal A*B exactly (max 15*15=225, no overflow possible in 8 bits).
REQ-025 Earliest back-to-back: start high during DONE is ignored; next operation accepted at edge N+6 or later (first IDLE edge).

Reset
REQ-026 reset=1 at any edge SHALL force state<=IDLE, P<=0, M<=0, ACC<=0, Q<=0, CNT<=0; busy=0, done=0 after that edge.
REQ-027 reset SHALL take priority over start and over any in-flight RUN/DONE state; the aborted operation SHALL NOT update P or pulse done.
REQ-028 With reset=1 and start=1 on the same edge, start SHALL be discarded.

Verification
REQ-029 Reset 2 cycles, A=4'hF, B=4'hF, start pulse 1 cycle -> busy=1 for 4 cycles, then done=1 one cycle with P=8'hE1 (225); P holds 8'hE1 afterwards.
REQ-030 A=4'b0101, B=4'b1010 -> P=8'h32 (50) at done; A=4'h0, B=4'h9 -> P=8'h00; A=1, B=1 -> P=8'h01.
REQ-031 Start 5*10, hold start=1 and change A=F, B=F during RUN/DONE -> exactly one done pulse, P=8'h32, no second operation until state returns to IDLE.
REQ-032 Start 15*15, assert reset at edge N+2 -> busy=0, done=0, P=8'h00 after that edge; no done pulse follows.
REQ-033 Exhaustive: all 256 (A,B) pairs, start at the first IDLE edge after each done -> every P equals A*B, done count = 256, busy/done never both 1.

Source files
------------

// File: rtl/sum4.sv
// sum4: 4-bit ripple adder used as the multiplier's single arithmetic unit.
// Ports:
//   A, B  - 4-bit addends
//   c_in  - carry in
//   S     - 4-bit sum
//   C_out - carry out
module sum4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  output logic [3:0] S,
  output logic       C_out
);

  assign {C_out, S} = {1'b0, A} + {1'b0, B} + {4'b0000, c_in};

endmodule

// File: rtl/mul4_seq.sv
// mul4_seq: sequential 4x4 -> 8 unsigned shift-and-add multiplier.
// One partial product is accumulated per clock over four RUN cycles, then the
// result is published in P with a one-cycle done pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   start - begin a multiplication (honoured only when idle)
//   A, B  - unsigned multiplicand / multiplier, captured on the accepting edge
//   P     - product register, holds the last completed result
//   busy  - high while the multiplication is iterating
//   done  - one-cycle pulse when P has just been updated
module mul4_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       carry;

  // Adding zero when the multiplier LSB is clear keeps ACC unchanged with C=0,
  // so the same shift path serves both cases.
  assign addend = q_q[0] ? m_q : 4'd0;

  sum4 u_adder (
    .A     (acc_q),
    .B     (addend),
    .c_in  (1'b0),
    .S     (sum),
    .C_out (carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = 4'd0;
          cnt_d   = 3'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        // {ACC,Q} <= {C, ACC', Q[3:1]}: consumed multiplier bit drops off Q.
        acc_d = {carry, sum[3:1]};
        q_d   = {sum[0], q_q[3:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          p_d     = {carry, sum, q_q[3:1]};
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      m_q     <= 4'd0;
      acc_q   <= 4'd0;
      q_q     <= 4'd0;
      cnt_q   <= 3'd0;
      p_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: a driver issues operations and pushes the
// arithmetic product into a scoreboard queue; a monitor pops on every done.
module tb_mul4_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       busy;
  logic       done;

  int         checks;
  int         errors;
  int         n_issued;
  int         n_done;
  bit         mon_en;
  logic [7:0] hold_p;
  logic [7:0] exp_q[$];

  mul4_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual P=%0h required no done pulse", P);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("product", {24'd0, P}, {24'd0, e});
          hold_p = e;
        end
      end else begin
        chk("p_hold", {24'd0, P}, {24'd0, hold_p});
      end
    end
  end

  // Issue one operation from IDLE and check the busy/done timeline.
  // When junk is set, start/A/B are scrambled while the operation runs.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit junk);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(8'(a * b));
    n_issued++;
    tick();                                 // accepting edge N
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (junk) begin
        A     = 4'($urandom);
        B     = 4'($urandom);
        start = 1'($urandom);
      end
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, 32'd0);
      tick();                               // edges N+1..N+4
    end
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    tick();                                 // edge N+5, back to IDLE
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_idle", {31'd0, done}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    n_issued = 0;
    n_done   = 0;
    mon_en   = 1'b0;
    hold_p   = 8'd0;
    reset    = 1'b1;
    start    = 1'b0;
    A        = 4'd0;
    B        = 4'd0;

    // Reset for two cycles with start asserted: start must be discarded.
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_p", {24'd0, P}, 32'd0);
    mon_en = 1'b1;
    tick();

    // Directed products.
    run_op(4'hF, 4'hF, 1'b0);
    tick();
    tick();
    chk("p_holds_e1", {24'd0, P}, 32'h0000_00E1);
    run_op(4'b0101, 4'b1010, 1'b0);
    run_op(4'h0, 4'h9, 1'b0);
    run_op(4'h1, 4'h1, 1'b0);

    // start held high and A/B changed during RUN/DONE: one operation only.
    A     = 4'd5;
    B     = 4'd10;
    start = 1'b1;
    exp_q.push_back(8'd50);
    n_issued++;
    tick();
    A = 4'hF;
    B = 4'hF;
    for (int i = 0; i < 5; i++) tick();     // through N+5, still ignored
    start = 1'b0;
    chk("held_start_p", {24'd0, P}, 32'h0000_0032);
    for (int i = 0; i < 4; i++) tick();

    // Reset at edge N+2 aborts the operation: no done, P cleared.
    A     = 4'hF;
    B     = 4'hF;
    start = 1'b1;
    tick();                                 // edge N
    start = 1'b0;
    tick();                                 // edge N+1
    reset = 1'b1;
    tick();                                 // edge N+2
    reset  = 1'b0;
    hold_p = 8'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_p", {24'd0, P}, 32'd0);
    for (int i = 0; i < 8; i++) tick();

    // Exhaustive, back-to-back at the first IDLE edge after each done.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b0);
      end
    end

    // Random operands, junk inputs while running, random idle gaps.
    for (int k = 0; k < 60; k++) begin
      run_op(4'($urandom), 4'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    for (int i = 0; i < 6; i++) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("done_count", n_done, n_issued);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
